// File: rtl/instruction_encoder_pkg.sv
// Shared types and constants for the x86-64 instruction encoder.
package instruction_encoder_pkg;

  localparam int ENC_DISP_W = 32;
  localparam int ENC_IMM_W  = 64;

  localparam logic [7:0] REX_BASE = 8'h40;
  localparam logic [7:0] ESC_0F   = 8'h0F;

  localparam logic [1:0] MOD_IND    = 2'b00;
  localparam logic [1:0] MOD_DISP8  = 2'b01;
  localparam logic [1:0] MOD_DISP32 = 2'b10;
  localparam logic [1:0] MOD_REG    = 2'b11;

  localparam logic [2:0] RM_SIB       = 3'b100;
  localparam logic [2:0] RM_DISP32    = 3'b101;
  localparam logic [2:0] SIB_NO_INDEX = 3'b100;

  // Encoding order matches the emission order; the FSM walks upward.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REX   = 3'd1,
    S_ESC   = 3'd2,
    S_OPC   = 3'd3,
    S_MODRM = 3'd4,
    S_SIB   = 3'd5,
    S_DISP  = 3'd6,
    S_IMM   = 3'd7
  } enc_state_t;

  typedef struct packed {
    logic                  rex_w;
    logic                  opc_2b;
    logic [7:0]            opcode;
    logic                  modrm_en;
    logic [3:0]            reg_id;
    logic                  mem;
    logic [3:0]            base;
    logic                  index_en;
    logic [3:0]            index;
    logic [1:0]            scale;
    logic [2:0]            disp_sz;
    logic [ENC_DISP_W-1:0] disp;
    logic [3:0]            imm_sz;
    logic [ENC_IMM_W-1:0]  imm;
  } enc_desc_t;

  // ModRM-related fields only matter when the instruction carries ModRM.
  function automatic logic enc_desc_legal(enc_desc_t d);
    logic disp_ok, imm_ok, idx_ok;
    disp_ok = (d.disp_sz == 3'd0) || (d.disp_sz == 3'd1) || (d.disp_sz == 3'd4);
    imm_ok  = (d.imm_sz == 4'd0) || (d.imm_sz == 4'd1) || (d.imm_sz == 4'd2) ||
              (d.imm_sz == 4'd4) || (d.imm_sz == 4'd8);
    idx_ok  = !(d.index_en && (d.index == 4'b0100));
    return d.modrm_en ? (disp_ok && imm_ok && idx_ok) : imm_ok;
  endfunction

endpackage

// File: rtl/instruction_encoder_modrm_sib_gen.sv
// Combinational derivation of REX, ModRM, SIB and the effective displacement.
module modrm_sib_gen
  import instruction_encoder_pkg::*;
(
  input  enc_desc_t              desc,
  output logic [7:0]             rex,
  output logic                   need_rex,
  output logic [7:0]             modrm,
  output logic [7:0]             sib,
  output logic                   need_sib,
  output logic [2:0]             eff_disp_sz,
  output logic [ENC_DISP_W-1:0]  eff_disp
);

  logic       r, x, b;
  logic [1:0] mod;
  logic [2:0] rm;
  logic       unused_fields;

  assign unused_fields = ^{desc.opc_2b, desc.opcode, desc.imm_sz, desc.imm};

  // Build prefix/addressing bytes; rbp/r13 base without disp needs a zero disp8.
  always_comb begin
    r           = desc.modrm_en & desc.reg_id[3];
    b           = desc.modrm_en & desc.base[3];
    x           = desc.modrm_en & desc.mem & desc.index_en & desc.index[3];
    rex         = REX_BASE | {4'b0000, desc.rex_w, r, x, b};
    need_rex    = desc.rex_w | r | x | b;
    need_sib    = 1'b0;
    eff_disp_sz = 3'd0;
    eff_disp    = desc.disp;
    mod         = MOD_REG;
    rm          = desc.base[2:0];
    if (desc.modrm_en && desc.mem) begin
      need_sib    = desc.index_en || (desc.base[2:0] == RM_SIB);
      rm          = need_sib ? RM_SIB : desc.base[2:0];
      eff_disp_sz = desc.disp_sz;
      case (desc.disp_sz)
        3'd1:    mod = MOD_DISP8;
        3'd4:    mod = MOD_DISP32;
        default: mod = MOD_IND;
      endcase
      if (desc.disp_sz == 3'd0 && desc.base[2:0] == RM_DISP32) begin
        mod         = MOD_DISP8;
        eff_disp_sz = 3'd1;
        eff_disp    = '0;
      end
    end
    modrm = {mod, desc.reg_id[2:0], rm};
    sib   = {desc.scale, desc.index_en ? desc.index[2:0] : SIB_NO_INDEX, desc.base[2:0]};
  end

endmodule

// File: rtl/instruction_encoder.sv
// Serialises one decoded x86-64 descriptor into machine-code bytes, one per cycle.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int DISP_W = ENC_DISP_W,
  parameter int IMM_W  = ENC_IMM_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rex_w,
  input  logic              in_opc_2b,
  input  logic [7:0]        in_opcode,
  input  logic              in_modrm_en,
  input  logic [3:0]        in_reg,
  input  logic              in_mem,
  input  logic [3:0]        in_base,
  input  logic              in_index_en,
  input  logic [3:0]        in_index,
  input  logic [1:0]        in_scale,
  input  logic [2:0]        in_disp_sz,
  input  logic [DISP_W-1:0] in_disp,
  input  logic [3:0]        in_imm_sz,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              err
);

  enc_desc_t                in_desc, desc_q, cur;
  enc_state_t               state, nxt;
  logic [2:0]               cnt;
  logic                     err_q;
  logic [7:0]               rex, modrm, sib;
  logic                     need_rex, need_sib;
  logic [2:0]               eff_disp_sz;
  logic [ENC_DISP_W-1:0]    eff_disp;
  logic [7:0]               present;
  logic                     field_done, accept, hs;

  // Pack the incoming fields into a descriptor.
  always_comb begin
    in_desc.rex_w    = in_rex_w;
    in_desc.opc_2b   = in_opc_2b;
    in_desc.opcode   = in_opcode;
    in_desc.modrm_en = in_modrm_en;
    in_desc.reg_id   = in_reg;
    in_desc.mem      = in_mem;
    in_desc.base     = in_base;
    in_desc.index_en = in_index_en;
    in_desc.index    = in_index;
    in_desc.scale    = in_scale;
    in_desc.disp_sz  = in_disp_sz;
    in_desc.disp     = ENC_DISP_W'(in_disp);
    in_desc.imm_sz   = in_imm_sz;
    in_desc.imm      = ENC_IMM_W'(in_imm);
  end

  // In IDLE the derived fields come from the live input so the first state is known at accept.
  assign cur = (state == S_IDLE) ? in_desc : desc_q;

  modrm_sib_gen u_gen (
    .desc        (cur),
    .rex         (rex),
    .need_rex    (need_rex),
    .modrm       (modrm),
    .sib         (sib),
    .need_sib    (need_sib),
    .eff_disp_sz (eff_disp_sz),
    .eff_disp    (eff_disp)
  );

  assign in_ready  = (state == S_IDLE) && !err_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != S_IDLE);
  assign hs        = out_valid && out_ready;
  assign err       = err_q;

  // Next present field after the current one; IDLE when nothing remains.
  always_comb begin
    present = {cur.imm_sz != 4'd0, eff_disp_sz != 3'd0, need_sib, cur.modrm_en,
               1'b1, cur.opc_2b, need_rex, 1'b0};
    nxt = S_IDLE;
    for (int i = 7; i >= 1; i--)
      if (i > int'(state) && present[i]) nxt = enc_state_t'(3'(i));
  end

  // Multi-byte fields finish when the byte counter reaches size-1.
  always_comb begin
    case (state)
      S_DISP:  field_done = (cnt == eff_disp_sz - 3'd1);
      S_IMM:   field_done = ({1'b0, cnt} == cur.imm_sz - 4'd1);
      default: field_done = 1'b1;
    endcase
  end

  assign out_last = out_valid && field_done && (nxt == S_IDLE);

  // Byte selection from the held descriptor; stable while stalled.
  always_comb begin
    case (state)
      S_REX:   out_byte = rex;
      S_ESC:   out_byte = ESC_0F;
      S_OPC:   out_byte = cur.opcode;
      S_MODRM: out_byte = modrm;
      S_SIB:   out_byte = sib;
      S_DISP:  out_byte = eff_disp[{cnt[1:0], 3'b000} +: 8];
      S_IMM:   out_byte = cur.imm[{cnt, 3'b000} +: 8];
      default: out_byte = 8'h00;
    endcase
  end

  // State, byte counter, descriptor capture and the error pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      desc_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        desc_q <= in_desc;
        cnt    <= '0;
        if (!enc_desc_legal(in_desc)) err_q <= 1'b1;
        else                          state <= nxt;
      end else if (hs) begin
        if (field_done) begin
          cnt   <= '0;
          state <= nxt;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: directed encodings plus randomized descriptors vs a byte-list model.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_rex_w = 1'b0, in_opc_2b = 1'b0, in_modrm_en = 1'b0, in_mem = 1'b0, in_index_en = 1'b0;
  logic [7:0]  in_opcode = '0;
  logic [3:0]  in_reg = '0, in_base = '0, in_index = '0, in_imm_sz = '0;
  logic [1:0]  in_scale = '0;
  logic [2:0]  in_disp_sz = '0;
  logic [31:0] in_disp = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b0, out_last, err;
  logic [7:0]  out_byte;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rex_w(in_rex_w), .in_opc_2b(in_opc_2b), .in_opcode(in_opcode),
    .in_modrm_en(in_modrm_en), .in_reg(in_reg), .in_mem(in_mem), .in_base(in_base),
    .in_index_en(in_index_en), .in_index(in_index), .in_scale(in_scale),
    .in_disp_sz(in_disp_sz), .in_disp(in_disp), .in_imm_sz(in_imm_sz), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .err(err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  byte unsigned exp_q[$];
  bit           exp_err;

  // Reference: list the bytes an assembler would produce for this operand form.
  task automatic model(input enc_desc_t d);
    int          dsz, modv, rmv, regl, basel;
    logic [31:0] dv;
    bit          w, r, x, b, use_sib;
    exp_q.delete();
    exp_err = !(d.imm_sz == 0 || d.imm_sz == 1 || d.imm_sz == 2 || d.imm_sz == 4 || d.imm_sz == 8);
    if (d.modrm_en)
      exp_err = exp_err || !(d.disp_sz == 0 || d.disp_sz == 1 || d.disp_sz == 4) ||
                (d.index_en && d.index == 4);
    if (exp_err) return;
    regl  = int'(d.reg_id) % 8;
    basel = int'(d.base) % 8;
    w = d.rex_w;
    r = d.modrm_en && d.reg_id >= 8;
    b = d.modrm_en && d.base >= 8;
    x = d.modrm_en && d.mem && d.index_en && d.index >= 8;
    if (w || r || x || b) exp_q.push_back(8'(64 + 8 * int'(w) + 4 * int'(r) + 2 * int'(x) + int'(b)));
    if (d.opc_2b) exp_q.push_back(8'h0F);
    exp_q.push_back(d.opcode);
    if (d.modrm_en) begin
      if (!d.mem) begin
        exp_q.push_back(8'(192 + regl * 8 + basel));
      end else begin
        dsz = int'(d.disp_sz);
        dv  = d.disp;
        if (dsz == 0 && basel == 5) begin dsz = 1; dv = 0; end
        modv    = (dsz == 0) ? 0 : (dsz == 1) ? 1 : 2;
        use_sib = d.index_en || basel == 4;
        rmv     = use_sib ? 4 : basel;
        exp_q.push_back(8'(modv * 64 + regl * 8 + rmv));
        if (use_sib)
          exp_q.push_back(8'(int'(d.scale) * 64 + (d.index_en ? int'(d.index) % 8 : 4) * 8 + basel));
        for (int k = 0; k < dsz; k++) exp_q.push_back(8'(dv >> (8 * k)));
      end
    end
    for (int k = 0; k < int'(d.imm_sz); k++) exp_q.push_back(8'(d.imm >> (8 * k)));
  endtask

  // Present one descriptor, then drain (or abort by reset after abort_at bytes).
  task automatic send(input enc_desc_t d, input bit stall, input int abort_at);
    int         idx, guard;
    bit         held, rdy;
    logic [7:0] held_b;
    model(d);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_rex_w = d.rex_w; in_opc_2b = d.opc_2b; in_opcode = d.opcode; in_modrm_en = d.modrm_en;
    in_reg = d.reg_id; in_mem = d.mem; in_base = d.base; in_index_en = d.index_en;
    in_index = d.index; in_scale = d.scale; in_disp_sz = d.disp_sz; in_disp = d.disp;
    in_imm_sz = d.imm_sz; in_imm = d.imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_err) begin
      chk("err_pulse", err, 1);
      chk("err_no_valid", out_valid, 0);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_in_ready", in_ready, 1);
      chk("err_still_no_valid", out_valid, 0);
      return;
    end
    chk("no_err", err, 0);
    idx = 0; guard = 0; held = 0; held_b = 0;
    while (idx < exp_q.size()) begin
      if (guard++ > 200) begin
        chk("drain_timeout", 64'(idx), 64'(exp_q.size()));
        return;
      end
      if (abort_at > 0 && idx == abort_at) begin
        reset_n = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_last", out_last, 0);
        reset_n = 1'b1;
        return;
      end
      chk("out_valid", out_valid, 1);
      if (held) chk("stall_stable", out_byte, held_b);
      rdy = stall ? 1'($urandom % 2) : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        chk($sformatf("byte%0d", idx), out_byte, exp_q[idx]);
        chk($sformatf("last%0d", idx), out_last, (idx == exp_q.size() - 1));
        idx++;
      end
      held = !rdy; held_b = out_byte;
      @(negedge clk);
    end
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
  endtask

  function automatic enc_desc_t mk(input bit w, input logic [7:0] opc, input bit modrm,
                                   input logic [3:0] rg, input bit mem, input logic [3:0] base);
    enc_desc_t d;
    d = '0;
    d.rex_w = w; d.opcode = opc; d.modrm_en = modrm; d.reg_id = rg; d.mem = mem; d.base = base;
    return d;
  endfunction

  initial begin
    enc_desc_t  d, c1, c4;
    logic [2:0] dsz_tab[8];
    logic [3:0] isz_tab[8];
    dsz_tab = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd4, 3'd2, 3'd3};
    isz_tab = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3, 4'd8};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_err", err, 0);
    reset_n = 1'b1;

    // add rax,rbx -> 48 01 D8
    c1 = mk(1, 8'h01, 1, 4'd3, 0, 4'd0);
    send(c1, 0, 0);
    // mov [rbp],ecx -> 89 4D 00
    d = mk(0, 8'h89, 1, 4'd1, 1, 4'd5);
    send(d, 0, 0);
    // mov r12,[rsp+8] -> 4C 8B 64 24 08
    d = mk(1, 8'h8B, 1, 4'd12, 1, 4'd4);
    d.disp_sz = 3'd1; d.disp = 32'd8;
    send(d, 0, 0);
    // mov rax,imm64 with random backpressure
    c4 = mk(1, 8'hB8, 0, 4'd0, 0, 4'd0);
    c4.imm_sz = 4'd8; c4.imm = 64'h1122334455667788;
    send(c4, 1, 0);
    // illegal disp size, illegal index
    d = mk(0, 8'h8B, 1, 4'd0, 1, 4'd3);
    d.disp_sz = 3'd3;
    send(d, 0, 0);
    d = mk(0, 8'h8B, 1, 4'd0, 1, 4'd3);
    d.index_en = 1'b1; d.index = 4'b0100;
    send(d, 0, 0);
    // reset mid-stream, then a clean encode
    send(c4, 0, 2);
    send(c1, 0, 0);

    for (int n = 0; n < 120; n++) begin
      d = '0;
      d.rex_w    = 1'($urandom);
      d.opc_2b   = 1'($urandom);
      d.opcode   = 8'($urandom);
      d.modrm_en = ($urandom % 4) != 0;
      d.reg_id   = 4'($urandom);
      d.mem      = 1'($urandom);
      d.base     = 4'($urandom);
      d.index_en = 1'($urandom);
      d.index    = 4'($urandom);
      d.scale    = 2'($urandom);
      d.disp_sz  = dsz_tab[$urandom % 8];
      d.disp     = $urandom;
      d.imm_sz   = isz_tab[$urandom % 8];
      d.imm      = {$urandom, $urandom};
      send(d, 1'($urandom), 0);
    end

    out_ready = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
